// File: rtl/sb_incr_initiator.sv
// Switchboard traffic initiator/checker for a byte-increment responder.
// Sends num_pkts deterministic packets of PKT_LEN words on TX, checks every
// returned word on RX against the +1-per-byte pattern, and counts errors.
module sb_incr_initiator #(
   parameter int          DW      = 256,
   parameter int          PKT_LEN = 2,
   parameter int          DEPTH   = 4,
   parameter logic [31:0] DEST    = 32'd0,
   parameter logic [7:0]  SEED    = 8'h00
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          start,
   input  logic [15:0]   num_pkts,
   output logic [DW-1:0] tx_data,
   output logic [31:0]   tx_dest,
   output logic          tx_last,
   output logic          tx_valid,
   input  logic          tx_ready,
   input  logic [DW-1:0] rx_data,
   input  logic [31:0]   rx_dest,
   input  logic          rx_last,
   input  logic          rx_valid,
   output logic          rx_ready,
   output logic          busy,
   output logic          done,
   output logic [15:0]   sent_pkts,
   output logic [15:0]   recv_pkts,
   output logic [15:0]   err_count,
   output logic [15:0]   first_err_word
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [15:0] LAST_POS = 16'(PKT_LEN - 1);
   localparam logic [15:0] DEPTH_W  = 16'(DEPTH);

   state_t          state_q, state_d;
   logic [15:0]     num_q, num_d;
   logic [15:0]     w_q, w_d;            // global tx word index
   logic [15:0]     r_q, r_d;            // global rx word index
   logic [15:0]     tx_pos_q, tx_pos_d;  // word position within tx packet
   logic [15:0]     rx_pos_q, rx_pos_d;  // word position within rx packet
   logic [15:0]     out_q, out_d;        // packets in flight
   logic [15:0]     sent_q, sent_d;
   logic [15:0]     recv_q, recv_d;
   logic [15:0]     err_q, err_d;
   logic [15:0]     first_err_q, first_err_d;
   logic            tx_valid_q, tx_valid_d;
   logic            tx_last_q, tx_last_d;
   logic [DW-1:0]   tx_data_q, tx_data_d;

   logic            rx_en;
   logic            tx_fire, rx_fire, tx_pkt_done, rx_pkt_done, rx_bad;
   logic            unused_rx;

   // Word whose byte i is base + i (mod 256).
   function automatic logic [DW-1:0] gen_word(input logic [7:0] base);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < DW/8; i++) v[i*8 +: 8] = base + 8'(i);
      return v;
   endfunction

   assign rx_en       = (state_q == RUN) || (state_q == DRAIN);
   assign tx_fire     = tx_valid_q & tx_ready;
   assign rx_fire     = rx_en & rx_valid;
   assign tx_pkt_done = tx_fire & tx_last_q;
   assign rx_pkt_done = rx_fire & rx_last;
   assign rx_bad      = (rx_data != gen_word(SEED + r_q[7:0] + 8'd1)) ||
                        (rx_last != (rx_pos_q == LAST_POS));
   assign unused_rx   = ^rx_dest;

   // Next-state: counters and checker first, then FSM (start overrides all).
   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      w_d         = w_q;
      r_d         = r_q;
      tx_pos_d    = tx_pos_q;
      rx_pos_d    = rx_pos_q;
      out_d       = out_q;
      sent_d      = sent_q;
      recv_d      = recv_q;
      err_d       = err_q;
      first_err_d = first_err_q;
      tx_valid_d  = tx_valid_q;
      tx_last_d   = tx_last_q;
      tx_data_d   = tx_data_q;

      if (tx_fire) begin
         w_d      = w_q + 16'd1;
         tx_pos_d = tx_last_q ? 16'd0 : tx_pos_q + 16'd1;
      end
      if (tx_pkt_done) sent_d = sent_q + 16'd1;

      if (rx_fire) begin
         r_d      = r_q + 16'd1;
         rx_pos_d = (rx_pos_q == LAST_POS) ? 16'd0 : rx_pos_q + 16'd1;
         if (rx_bad) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    first_err_d = r_q;
         end
      end
      if (rx_pkt_done) recv_d = recv_q + 16'd1;

      case ({tx_pkt_done, rx_pkt_done})
         2'b10:   out_d = out_q + 16'd1;
         2'b01:   out_d = out_q - 16'd1;
         default: out_d = out_q;
      endcase

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               num_d       = num_pkts;
               w_d         = '0;
               r_d         = '0;
               tx_pos_d    = '0;
               rx_pos_d    = '0;
               out_d       = '0;
               sent_d      = '0;
               recv_d      = '0;
               err_d       = '0;
               first_err_d = '0;
               if (num_pkts == 16'd0) begin
                  state_d    = DONE;
                  tx_valid_d = 1'b0;
               end else begin
                  state_d    = RUN;
                  tx_valid_d = 1'b1;
                  tx_data_d  = gen_word(SEED);
                  tx_last_d  = (LAST_POS == 16'd0);
               end
            end
         end
         RUN: begin
            if (tx_pkt_done && (sent_d == num_q)) begin
               tx_valid_d = 1'b0;
               state_d    = (recv_d == num_q) ? DONE : DRAIN;
            end else if (!tx_valid_q || tx_fire) begin
               // Mid-packet words always go; depth/count gate only a new packet.
               if (tx_pos_d != 16'd0) tx_valid_d = 1'b1;
               else tx_valid_d = (out_d < DEPTH_W) && (sent_d < num_q);
               tx_data_d = gen_word(SEED + w_d[7:0]);
               tx_last_d = (tx_pos_d == LAST_POS);
            end
         end
         DRAIN: begin
            if (recv_d == num_q) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q     <= IDLE;
         num_q       <= '0;
         w_q         <= '0;
         r_q         <= '0;
         tx_pos_q    <= '0;
         rx_pos_q    <= '0;
         out_q       <= '0;
         sent_q      <= '0;
         recv_q      <= '0;
         err_q       <= '0;
         first_err_q <= '0;
         tx_valid_q  <= 1'b0;
         tx_last_q   <= 1'b0;
         tx_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         w_q         <= w_d;
         r_q         <= r_d;
         tx_pos_q    <= tx_pos_d;
         rx_pos_q    <= rx_pos_d;
         out_q       <= out_d;
         sent_q      <= sent_d;
         recv_q      <= recv_d;
         err_q       <= err_d;
         first_err_q <= first_err_d;
         tx_valid_q  <= tx_valid_d;
         tx_last_q   <= tx_last_d;
         tx_data_q   <= tx_data_d;
      end
   end

   assign tx_data        = tx_data_q;
   assign tx_dest        = DEST;
   assign tx_last        = tx_last_q;
   assign tx_valid       = tx_valid_q;
   assign rx_ready       = rx_en;
   assign busy           = rx_en;
   assign done           = (state_q == DONE);
   assign sent_pkts      = sent_q;
   assign recv_pkts      = recv_q;
   assign err_count      = err_q;
   assign first_err_word = first_err_q;

endmodule

// File: tb/tb_sb_incr_initiator.sv
// Bench for sb_incr_initiator: a queued increment responder with optional
// stalls/corruption (or zero-delay combinational loopback) plus a tx scoreboard.
module tb_sb_incr_initiator;
   localparam int DW      = 256;
   localparam int PKT_LEN = 2;
   localparam int DEPTH   = 4;

   typedef struct { logic [DW-1:0] data; logic last; } word_t;

   logic          clk = 1'b0;
   logic          nreset;
   logic          start;
   logic [15:0]   num_pkts;
   logic [DW-1:0] tx_data, rx_data;
   logic [31:0]   tx_dest, rx_dest;
   logic          tx_last, tx_valid, tx_ready;
   logic          rx_last, rx_valid, rx_ready;
   logic          busy, done;
   logic [15:0]   sent_pkts, recv_pkts, err_count, first_err_word;

   // responder controls/state
   logic          loop_mode = 1'b0, rx_en = 1'b1, stall_en = 1'b0;
   int            corrupt_idx = -1, drop_idx = -1;
   logic          rsp_tx_ready = 1'b0, rsp_valid = 1'b0, rsp_last = 1'b0;
   logic [DW-1:0] rsp_data = '0;
   word_t         exp_q[$];
   word_t         rsp_q[$];
   int            rsp_idx, tb_sent, tb_recv, tx_words, max_out, stable_viol;
   logic          prev_hold = 1'b0, prev_last;
   logic [DW-1:0] prev_data;
   int            checks = 0, errors = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] inc_word(input logic [DW-1:0] d);
      logic [DW-1:0] v;
      for (int i = 0; i < DW/8; i++) v[i*8 +: 8] = d[i*8 +: 8] + 8'd1;
      return v;
   endfunction

   function automatic logic [DW-1:0] exp_word(input int w);
      logic [DW-1:0] v;
      for (int i = 0; i < DW/8; i++) v[i*8 +: 8] = 8'((w + i) & 255);
      return v;
   endfunction

   assign tx_ready = loop_mode ? rx_ready : rsp_tx_ready;
   assign rx_valid = loop_mode ? tx_valid : rsp_valid;
   assign rx_data  = loop_mode ? inc_word(tx_data) : rsp_data;
   assign rx_last  = loop_mode ? tx_last : rsp_last;
   assign rx_dest  = 32'd0;

   sb_incr_initiator #(.DW(DW), .PKT_LEN(PKT_LEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .nreset(nreset), .start(start), .num_pkts(num_pkts),
      .tx_data(tx_data), .tx_dest(tx_dest), .tx_last(tx_last),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_dest(rx_dest), .rx_last(rx_last),
      .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .done(done), .sent_pkts(sent_pkts), .recv_pkts(recv_pkts),
      .err_count(err_count), .first_err_word(first_err_word));

   // Responder + tx scoreboard: drive inputs at negedge, then account for the
   // transfers the coming posedge will perform.
   always @(negedge clk) begin
      logic  txr, rxv, rxl, txf, rxf;
      word_t e, r;
      if (nreset !== 1'b1) begin
         rsp_valid    = 1'b0;
         rsp_tx_ready = 1'b0;
         prev_hold    = 1'b0;
      end else begin
         rsp_tx_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (!loop_mode && rx_en && rsp_q.size() != 0 &&
             (!stall_en || $urandom_range(0, 1) == 1)) begin
            rsp_valid = 1'b1;
            rsp_data  = rsp_q[0].data;
            rsp_last  = rsp_q[0].last;
         end else begin
            rsp_valid = 1'b0;
         end
         txr = loop_mode ? rx_ready : rsp_tx_ready;
         rxv = loop_mode ? tx_valid : rsp_valid;
         rxl = loop_mode ? tx_last : rsp_last;
         txf = tx_valid && txr;
         rxf = rxv && rx_ready;
         if (prev_hold && (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last))
            stable_viol++;
         prev_hold = tx_valid && !txr;
         prev_data = tx_data;
         prev_last = tx_last;
         if (txf) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL tx_extra word %0d observed, none expected", tx_words);
            end else begin
               e = exp_q.pop_front();
               if (tx_data !== e.data || tx_last !== e.last) begin
                  errors++;
                  $display("FAIL tx_word %0d got data=%h last=%b expected data=%h last=%b",
                           tx_words, tx_data, tx_last, e.data, e.last);
               end
            end
            tx_words++;
            if (!loop_mode) begin
               r.data = inc_word(tx_data);
               r.last = tx_last;
               if (rsp_idx == corrupt_idx) r.data[47:40] = r.data[47:40] ^ 8'h5A;
               if (rsp_idx == drop_idx)    r.last = 1'b0;
               rsp_q.push_back(r);
               rsp_idx++;
            end
            if (tx_last) tb_sent++;
         end
         if (rxf) begin
            if (!loop_mode) r = rsp_q.pop_front();
            if (rxl) tb_recv++;
         end
         if (tb_sent - tb_recv > max_out) max_out = tb_sent - tb_recv;
      end
   end

   task automatic do_start(input int n);
      word_t e;
      exp_q.delete();
      rsp_q.delete();
      rsp_idx = 0; tb_sent = 0; tb_recv = 0; tx_words = 0; max_out = 0; stable_viol = 0;
      for (int w = 0; w < n * PKT_LEN; w++) begin
         e.data = exp_word(w);
         e.last = ((w % PKT_LEN) == PKT_LEN - 1);
         exp_q.push_back(e);
      end
      num_pkts = 16'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while (done !== 1'b1 && n < maxc) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({tx_valid, rx_ready, busy, done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl got %b expected 0000", {tx_valid, rx_ready, busy, done});
      end
      checks++;
      if (sent_pkts !== 0 || recv_pkts !== 0 || err_count !== 0 || first_err_word !== 0) begin
         errors++;
         $display("FAIL reset_counters got %0d %0d %0d %0d expected all 0",
                  sent_pkts, recv_pkts, err_count, first_err_word);
      end
      checks++;
      if (tx_data !== '0 || tx_last !== 1'b0 || tx_dest !== 32'd0) begin
         errors++;
         $display("FAIL reset_tx got last=%b dest=%h expected 0 with zero data", tx_last, tx_dest);
      end
      @(negedge clk);
      nreset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({tx_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset got %b expected 000", {tx_valid, busy, done});
      end
   endtask

   task automatic test_loopback;
      loop_mode = 1'b1;
      do_start(4);
      checks++;
      if (tx_valid !== 1'b1 || tx_data[7:0] !== 8'h00 || tx_data[255:248] !== 8'h1F) begin
         errors++;
         $display("FAIL loop_first_word got valid=%b b0=%h b31=%h expected 1 00 1f",
                  tx_valid, tx_data[7:0], tx_data[255:248]);
      end
      wait_done(100);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL loop_done got done=%b busy=%b expected 1 0", done, busy);
      end
      checks++;
      if (sent_pkts !== 16'd4 || recv_pkts !== 16'd4 || err_count !== 16'd0) begin
         errors++;
         $display("FAIL loop_counts got sent=%0d recv=%0d err=%0d expected 4 4 0",
                  sent_pkts, recv_pkts, err_count);
      end
      checks++;
      if (tx_words != 8 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL loop_words got %0d left=%0d expected 8 0", tx_words, exp_q.size());
      end
      loop_mode = 1'b0;
   endtask

   task automatic test_depth;
      rx_en = 1'b0;
      do_start(10);
      repeat (30) @(negedge clk);
      checks++;
      if (tx_words != 8 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL depth_stop got words=%0d valid=%b expected 8 0", tx_words, tx_valid);
      end
      checks++;
      if (sent_pkts !== 16'd4 || recv_pkts !== 16'd0 || busy !== 1'b1 || max_out != DEPTH) begin
         errors++;
         $display("FAIL depth_state got sent=%0d recv=%0d busy=%b maxout=%0d expected 4 0 1 4",
                  sent_pkts, recv_pkts, busy, max_out);
      end
      rx_en = 1'b1;
      wait_done(300);
      checks++;
      if (done !== 1'b1 || err_count !== 16'd0 || sent_pkts !== 16'd10 || recv_pkts !== 16'd10) begin
         errors++;
         $display("FAIL depth_finish got done=%b err=%0d sent=%0d recv=%0d expected 1 0 10 10",
                  done, err_count, sent_pkts, recv_pkts);
      end
   endtask

   task automatic test_corrupt;
      corrupt_idx = 3;
      do_start(4);
      wait_done(200);
      checks++;
      if (done !== 1'b1 || err_count !== 16'd1 || first_err_word !== 16'd3 || recv_pkts !== 16'd4) begin
         errors++;
         $display("FAIL corrupt got done=%b err=%0d first=%0d recv=%0d expected 1 1 3 4",
                  done, err_count, first_err_word, recv_pkts);
      end
      corrupt_idx = -1;
   endtask

   task automatic test_zero;
      logic seen = 1'b0;
      do_start(0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_done got done=%b busy=%b expected 1 0", done, busy);
      end
      for (int i = 0; i < 6; i++) begin
         seen |= tx_valid;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0 || sent_pkts !== 0 || recv_pkts !== 0 || err_count !== 0 || first_err_word !== 0) begin
         errors++;
         $display("FAIL zero_run got valid_seen=%b counts %0d %0d %0d %0d expected 0 and all 0",
                  seen, sent_pkts, recv_pkts, err_count, first_err_word);
      end
   endtask

   task automatic test_drop_last;
      drop_idx = 1;
      do_start(4);
      repeat (40) @(negedge clk);
      checks++;
      if (err_count !== 16'd1 || first_err_word !== 16'd1 || recv_pkts !== 16'd3 || tx_words != 8) begin
         errors++;
         $display("FAIL drop_err got err=%0d first=%0d recv=%0d words=%0d expected 1 1 3 8",
                  err_count, first_err_word, recv_pkts, tx_words);
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_drain got busy=%b done=%b valid=%b expected 1 0 0", busy, done, tx_valid);
      end
      nreset = 1'b0;
      #1;
      checks++;
      if ({tx_valid, rx_ready, busy, done, tx_last} !== 5'b0 || tx_data !== '0 ||
          sent_pkts !== 0 || recv_pkts !== 0 || err_count !== 0 || first_err_word !== 0) begin
         errors++;
         $display("FAIL drop_reset got ctl=%b sent=%0d recv=%0d err=%0d first=%0d expected all 0",
                  {tx_valid, rx_ready, busy, done, tx_last}, sent_pkts, recv_pkts, err_count, first_err_word);
      end
      @(negedge clk);
      nreset = 1'b1;
      drop_idx = -1;
      @(negedge clk);
      checks++;
      if ({busy, done, tx_valid} !== 3'b000) begin
         errors++;
         $display("FAIL drop_idle got %b expected 000", {busy, done, tx_valid});
      end
   endtask

   task automatic test_stall;
      stall_en = 1'b1;
      do_start(300);
      wait_done(30000);
      stall_en = 1'b0;
      checks++;
      if (done !== 1'b1 || err_count !== 16'd0 || sent_pkts !== 16'd300 || recv_pkts !== 16'd300) begin
         errors++;
         $display("FAIL stall_finish got done=%b err=%0d sent=%0d recv=%0d expected 1 0 300 300",
                  done, err_count, sent_pkts, recv_pkts);
      end
      checks++;
      if (max_out > DEPTH || max_out < 1 || stable_viol != 0) begin
         errors++;
         $display("FAIL stall_flow got maxout=%0d unstable=%0d expected 1..4 and 0", max_out, stable_viol);
      end
      checks++;
      if (tx_words != 600 || exp_q.size() != 0 || tb_recv != 300) begin
         errors++;
         $display("FAIL stall_words got words=%0d left=%0d rxpkts=%0d expected 600 0 300",
                  tx_words, exp_q.size(), tb_recv);
      end
   endtask

   initial begin
      nreset   = 1'b1;
      start    = 1'b0;
      num_pkts = 16'd0;
      #1 nreset = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      test_loopback;
      test_depth;
      test_corrupt;
      test_zero;
      test_drop_last;
      test_stall;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sb_incr_initiator.md
Name: sb_incr_initiator

Overview:
- Traffic initiator and checker for a switchboard byte-increment responder, i.e. a block that returns each packet with every byte incremented by 1 (mod 256).
- Generates deterministic multi-word packets on an SB TX port and receives the responses on an SB RX port.
- Checks every returned word against the expected increment and counts errors.
- Used as the self-checking host side in the router/loopback example benches and in FPGA smoke tests.

Parameters:
- DW, 256, data width in bits; must be a multiple of 8.
- PKT_LEN, 2, words per packet (>=1); tx_last is asserted on the final word.
- DEPTH, 4, maximum packets in flight (sent but not fully returned).
- DEST, 0, constant value driven on tx_dest (32 bits).
- SEED, 8'h00, byte offset for payload generation.

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a run when in IDLE or DONE
- num_pkts  input  16  packets to send in the run; sampled on start
- tx_data  output  DW  outgoing word
- tx_dest  output  32  outgoing destination (= DEST)
- tx_last  output  1  final word of packet
- tx_valid  output  1  tx word valid
- tx_ready  input  1  downstream accepts tx word
- rx_data  input  DW  returned word
- rx_dest  input  32  ignored
- rx_last  input  1  returned final-word flag
- rx_valid  input  1  rx word valid
- rx_ready  output  1  block accepts rx word
- busy  output  1  high in RUN or DRAIN
- done  output  1  high in DONE
- sent_pkts  output  16  packets fully accepted on tx
- recv_pkts  output  16  packets fully received on rx
- err_count  output  16  mismatched words; saturates at 16'hFFFF
- first_err_word  output  16  global rx word index of first error; valid when err_count != 0

Behaviour:
- Reset (async assert, sync release): state IDLE; tx_valid, rx_ready, busy, done = 0; all counters = 0; tx_data, tx_last = 0.
- Handshake (both ports): a transfer occurs in any cycle with valid && ready.
  - tx_valid, tx_data and tx_last are held stable until accepted; tx_valid never drops without a transfer.
  - rx_ready does not depend combinationally on rx_valid.
- Payload generation: w is the global tx word index (0 at run start), wrapping at 2^16.
  - tx byte i of word w = (SEED + w + i) mod 256.
  - tx_last = 1 when (w mod PKT_LEN) == PKT_LEN-1.
- Checking: r is the global rx word index.
  - Expected rx byte i = (SEED + r + i + 1) mod 256.
  - Expected rx_last = ((r mod PKT_LEN) == PKT_LEN-1).
  - A word is in error if any byte mismatches or rx_last differs; such a word adds exactly 1 to err_count.
  - first_err_word is captured only on the first error of a run.
- Flow control: outstanding = packets sent minus packets received.
  - Incremented on tx acceptance of a last word; decremented on rx acceptance of a last word.
  - Both in the same cycle: unchanged.
  - tx_valid may assert only when outstanding < DEPTH and sent_pkts < num_pkts_latched.
  - A packet in progress is always completed even if outstanding reaches DEPTH mid-packet; the check is made only at packet start.
- FSM:
  - IDLE: rx_ready=0. On start, latch num_pkts, clear counters, w, r and outstanding. Go to RUN, or to DONE if num_pkts==0.
  - RUN: rx_ready=1; generate and check concurrently. When the last word of packet num_pkts is accepted on tx, go to DRAIN. If outstanding is already 0 at that point (the same-cycle rx completes the final packet), go to DONE.
  - DRAIN: tx_valid=0, rx_ready=1. When recv_pkts reaches the latched count, go to DONE.
  - DONE: done=1, rx_ready=0; counters hold. start restarts as from IDLE; start in RUN or DRAIN is ignored.
- Latency: the first tx word is valid the cycle after start; done asserts the cycle after the final rx last-word transfer.
- Reset asserted mid-run: immediate return to IDLE; in-flight data is discarded.

Test Plan:
- Loopback via an increment responder with zero delay; num_pkts=4, PKT_LEN=2 -> 8 tx words, first word byte0=0x00 and byte31=0x1F; sent_pkts=4, recv_pkts=4, err_count=0, done=1.
- Responder holds rx_valid low and tx_ready=1; num_pkts=10, DEPTH=4 -> exactly 8 tx words accepted, then tx_valid=0. Releasing responses completes the run with err_count=0.
- Responder corrupts byte 5 of returned word 3 -> err_count=1, first_err_word=3, recv_pkts=num_pkts.
- Responder drops rx_last on word 1 (PKT_LEN=2) -> error counted at r=1, first_err_word=1; block then waits in DRAIN. Bench checks busy=1, then applies reset -> all outputs 0, state IDLE.
- start with num_pkts=0 -> done=1 the next cycle, tx_valid never asserts, all counters 0.
- Random tx_ready/rx_valid stalls (50%), num_pkts=300 -> tx data stable under stall, outstanding never exceeds 4, err_count=0, sent_pkts=recv_pkts=300.
